// File: rtl/sample_ram_seq.sv
// Sequencer for the 4ch x 128-sample FastICA buffer RAM.
// Ports: clk, rst, start, abort, num_passes, in_valid -> in_ready, ram_en/rw/addr, rd_valid/last, pass_idx, busy, done.
module sample_ram_seq #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 14,
  parameter int CNT_W  = 8,
  parameter int PASS_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [PASS_W-1:0] num_passes,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ram_en,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              rd_valid,
  output logic              rd_last,
  output logic [PASS_W-1:0] pass_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE, LOAD, GAP, READ, FIN
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [PASS_W-1:0] passes, passes_n;
  logic [PASS_W-1:0] pass_n;
  logic              at_last;

  assign at_last = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      pass_idx <= '0;
      passes   <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pass_idx <= pass_n;
      passes   <= passes_n;
      // RAM q is registered, so read status trails the issue by one cycle.
      // An abort does not cancel a read already issued.
      rd_valid <= (state == READ);
      rd_last  <= (state == READ) && at_last;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    pass_n   = pass_idx;
    passes_n = passes;
    in_ready = 1'b0;
    ram_en   = 1'b0;
    ram_rw   = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          passes_n = (num_passes == '0) ? PASS_W'(1) : num_passes;
          cnt_n    = '0;
          pass_n   = '0;
          state_n  = LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        ram_rw   = 1'b1;
        // Never raise En without a sample: the RAM's own counter would move.
        ram_en   = in_valid;
        if (in_valid) begin
          if (at_last) begin
            cnt_n   = '0;
            state_n = GAP;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      GAP: begin
        // En low for one cycle clears the RAM's internal counter.
        state_n = READ;
      end
      READ: begin
        ram_en = 1'b1;
        if (at_last) begin
          cnt_n = '0;
          if (pass_idx == passes - PASS_W'(1)) begin
            state_n = FIN;
          end else begin
            pass_n  = pass_idx + PASS_W'(1);
            state_n = GAP;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      FIN: begin
        done    = 1'b1;
        pass_n  = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n = IDLE;
      cnt_n   = '0;
      pass_n  = '0;
    end
  end

  assign ram_addr = {{(ADDR_W - CNT_W){1'b0}}, cnt};
  assign busy     = (state != IDLE);

endmodule
